// File: rtl/ps2_mouse_pkg.sv
// rtl/ps2_mouse_pkg.sv - shared states, PS/2 command/response bytes and error codes for the mouse init sequencer
package ps2_mouse_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_NEXT,
        ST_RESTART,
        ST_STREAM,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        RESP_ACK,
        RESP_ACK_BAT_ID,
        RESP_ACK_ID
    } resp_kind_e;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_RATE   = 8'hF3;
    localparam logic [7:0] CMD_GETID  = 8'hF2;
    localparam logic [7:0] CMD_STREAM = 8'hF4;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERR    = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_TX_TMO   = 3'd1;
    localparam logic [2:0] ERR_RESP_TMO = 3'd2;
    localparam logic [2:0] ERR_BAT_TMO  = 3'd3;
    localparam logic [2:0] ERR_BAD_ID   = 3'd4;
    localparam logic [2:0] ERR_DEV      = 3'd5;

    localparam int STEP_W = 4;
`ifdef MOUSE_WHEEL_EN
    localparam int SCRIPT_LEN = 11;
`else
    localparam int SCRIPT_LEN = 4;
`endif

    function automatic int retry_width(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/ps2_mouse_cmd_rom.sv
// rtl/ps2_mouse_cmd_rom.sv - init script lookup: step -> command byte, expected reply kind, last flag
module ps2_mouse_cmd_rom
    import ps2_mouse_pkg::*;
#(
    parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
    input  logic [STEP_W-1:0] step_i,
    output logic [7:0]        byte_o,
    output resp_kind_e        kind_o,
    output logic              last_o
);

    always_comb begin
        byte_o = CMD_STREAM;
        kind_o = RESP_ACK;
        last_o = (step_i == STEP_W'(SCRIPT_LEN - 1));
        case (step_i)
            4'd0: begin
                byte_o = CMD_RESET;
                kind_o = RESP_ACK_BAT_ID;
            end
            4'd1: byte_o = CMD_RATE;
            4'd2: byte_o = SAMPLE_RATE;
`ifdef MOUSE_WHEEL_EN
            // IntelliMouse knock: rates 200, 100, 80 then read the ID back
            4'd3: byte_o = CMD_RATE;
            4'd4: byte_o = 8'hC8;
            4'd5: byte_o = CMD_RATE;
            4'd6: byte_o = 8'h64;
            4'd7: byte_o = CMD_RATE;
            4'd8: byte_o = 8'h50;
            4'd9: begin
                byte_o = CMD_GETID;
                kind_o = RESP_ACK_ID;
            end
`endif
            default: byte_o = CMD_STREAM;
        endcase
    end

endmodule

// File: rtl/ps2_mouse_init_seq.sv
// rtl/ps2_mouse_init_seq.sv - PS/2 mouse bring-up sequencer to stream mode; MOUSE_WHEEL_EN adds the wheel knock
module ps2_mouse_init_seq
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 2_000_000,
    parameter int unsigned BAT_TIMEOUT = 100_000_000,
    parameter int          MAX_RETRY   = 3,
    parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tx_done_sig,
    input  logic       rx_done_sig,
    input  logic [7:0] d_rec,
    output logic       send_en,
    output logic [7:0] d_send,
    output logic       busy,
    output logic       ready,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] dev_id,
    output logic       pkt_valid,
    output logic [7:0] pkt_data
);

    localparam int RETRY_W = retry_width(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [2:0]          code_q, code_d;
    logic [7:0]          dev_id_q, dev_id_d;

    logic [7:0]  rom_byte;
    resp_kind_e  rom_kind;
    logic        rom_last;
    logic        waiting;
    logic        tmo;

    ps2_mouse_cmd_rom #(
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_rom (
        .step_i (step_q),
        .byte_o (rom_byte),
        .kind_o (rom_kind),
        .last_o (rom_last)
    );

    assign waiting = (state_q == ST_WAIT_TX) || (state_q == ST_WAIT_ACK) ||
                     (state_q == ST_WAIT_BAT) || (state_q == ST_WAIT_ID);
    assign tmo = (state_q == ST_WAIT_BAT) ? (cnt_q == 32'(BAT_TIMEOUT - 1))
                                          : (cnt_q == 32'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            retry_q  <= '0;
            cnt_q    <= '0;
            code_q   <= ERR_NONE;
            dev_id_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            retry_q  <= retry_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            dev_id_q <= dev_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        retry_d  = retry_q;
        code_d   = code_q;
        dev_id_d = dev_id_q;
        case (state_q)
            ST_IDLE, ST_STREAM, ST_ERROR: begin
                if (start) begin
                    state_d = ST_SEND;
                    step_d  = '0;
                    retry_d = '0;
                    code_d  = ERR_NONE;
                end
            end
            ST_SEND: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                // a response byte arriving before tx_done is not ours to consume
                if (tx_done_sig) begin
                    state_d = ST_WAIT_ACK;
                end else if (tmo) begin
                    state_d = ST_RESTART;
                    code_d  = ERR_TX_TMO;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_done_sig) begin
                    if (d_rec == RSP_ACK) begin
                        case (rom_kind)
                            RESP_ACK_BAT_ID: state_d = ST_WAIT_BAT;
                            RESP_ACK_ID:     state_d = ST_WAIT_ID;
                            default:         state_d = ST_NEXT;
                        endcase
                    end else if (d_rec == RSP_RESEND && retry_q != RETRY_MAX) begin
                        state_d = ST_SEND;
                        retry_d = retry_q + RETRY_W'(1);
                    end else begin
                        state_d = ST_RESTART;
                        code_d  = ERR_DEV;
                    end
                end else if (tmo) begin
                    state_d = ST_RESTART;
                    code_d  = ERR_RESP_TMO;
                end
            end
            ST_WAIT_BAT: begin
                if (rx_done_sig) begin
                    if (d_rec == RSP_BAT_OK) begin
                        state_d = ST_WAIT_ID;
                    end else begin
                        state_d = ST_RESTART;
                        code_d  = ERR_BAD_ID;
                    end
                end else if (tmo) begin
                    state_d = ST_RESTART;
                    code_d  = ERR_BAT_TMO;
                end
            end
            ST_WAIT_ID: begin
                if (rx_done_sig) begin
`ifdef MOUSE_WHEEL_EN
                    if (rom_kind == RESP_ACK_ID && d_rec != 8'h03 && d_rec != 8'h00) begin
                        state_d = ST_RESTART;
                        code_d  = ERR_BAD_ID;
                    end else begin
                        dev_id_d = d_rec;
                        state_d  = ST_NEXT;
                    end
`else
                    dev_id_d = d_rec;
                    state_d  = ST_NEXT;
`endif
                end else if (tmo) begin
                    state_d = ST_RESTART;
                    code_d  = ERR_RESP_TMO;
                end
            end
            ST_NEXT: begin
                if (rom_last) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_SEND;
                    step_d  = step_q + STEP_W'(1);
                end
            end
            ST_RESTART: begin
                if (retry_q == RETRY_MAX) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_SEND;
                    step_d  = '0;
                    retry_d = retry_q + RETRY_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // timeout window restarts whenever the state changes, including FE resends
    always_comb begin
        cnt_d = '0;
        if (waiting && state_d == state_q) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign send_en   = (state_q == ST_SEND);
    assign d_send    = (state_q == ST_SEND || state_q == ST_WAIT_TX) ? rom_byte : 8'h00;
    assign busy      = !(state_q == ST_IDLE || state_q == ST_STREAM || state_q == ST_ERROR);
    assign ready     = (state_q == ST_STREAM);
    assign err       = (state_q == ST_ERROR);
    assign err_code  = (state_q == ST_ERROR) ? code_q : ERR_NONE;
    assign dev_id    = dev_id_q;
    assign pkt_valid = (state_q == ST_STREAM) && rx_done_sig;
    assign pkt_data  = (state_q == ST_STREAM) ? d_rec : 8'h00;

endmodule
